load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter READ_WAIT, default 1, SHALL set the number of cycles memory read signals are held before read data is sampled (legal 1..3).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 req_valid  input  1  execute stage offers a memory request.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  4  target memory address.
REQ-008 req_wdata  input  8  store data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  downstream accepts response.
REQ-011 rsp_rdata  output  8  load data (store: echo of written data).
REQ-012 rsp_err  output  1  store read-back mismatch flag.
REQ-013 mem_data_out  input  8  read data from memory bank.
REQ-014 mem_data_in  output  8  write data to memory bank.
REQ-015 mem_addr_in  output  4  memory write address.
REQ-016 mem_addr_out  output  4  memory read address.
REQ-017 mem_r_w  output  1  1 = read, 0 = write.
REQ-018 mem_enable  output  1  memory access strobe.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, VERIFY (macro only), RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready, latching req_we, req_addr, req_wdata.
REQ-021 Accept with req_we=1 SHALL go IDLE->WRITE; with req_we=0 SHALL go IDLE->READ.
REQ-022 WRITE SHALL last exactly one cycle driving mem_r_w=0, mem_enable=1, mem_addr_in=latched addr, mem_data_in=latched data, then go to RESP (or VERIFY with macro).
REQ-023 READ SHALL last READ_WAIT cycles driving mem_r_w=1, mem_enable=1, mem_addr_out=latched addr, using an internal wait counter; mem_data_out SHALL be captured into rsp_rdata on the final READ cycle edge, then go to RESP.
REQ-024 Outside WRITE/READ/VERIFY: mem_enable=0, mem_r_w=1 (never a stray write), memory address/data outputs hold last values.
REQ-025 RESP SHALL assert rsp_valid with rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then return to IDLE on that edge.
REQ-026 Load latency: accept edge to rsp_valid = READ_WAIT+1 cycles; store latency = 2 cycles (macro off).
REQ-027 req_valid while not IDLE SHALL be ignored (no queueing); back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-028 rsp_rdata for a store SHALL equal the latched req_wdata.
REQ-029 mem_r_w SHALL be 0 in at most one cycle per accepted store.

Reset
REQ-030 Assertion of reset SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, mem_enable=0, mem_r_w=1, mem_addr_in=mem_addr_out=4'h0, mem_data_in=8'h00, wait counter=0.
REQ-031 Reset during WRITE/READ/VERIFY/RESP SHALL abort the operation with no response; a write in progress SHALL not be re-issued after reset.

Configuration
REQ-032 Macro LSU_WRITE_VERIFY_EN defined: after WRITE, the unit SHALL enter VERIFY for READ_WAIT cycles (mem_r_w=1, mem_enable=1, mem_addr_out=latched addr), compare mem_data_out to latched data on the final cycle, set rsp_err=1 on mismatch, then go to RESP; store latency = READ_WAIT+2.
REQ-033 Macro undefined: no VERIFY state or comparator, rsp_err SHALL be constant 0.

Verification
REQ-034 Reset, then store addr 4'h3 data 8'hA5 -> one cycle mem_r_w=0, mem_enable=1, mem_addr_in=3, mem_data_in=A5; rsp_valid 2 cycles after accept, rsp_rdata=A5, rsp_err=0.
REQ-035 READ_WAIT=2, load addr 4'hF with memory returning 8'h3C -> mem_r_w=1 for 2 cycles, rsp_valid 3 cycles after accept, rsp_rdata=3C.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-037 Assert reset during READ -> all outputs at reset values immediately, no rsp_valid after release, next load completes normally.
REQ-038 LSU_WRITE_VERIFY_EN defined, model forces mem_data_out=8'h00 after store of 8'h5A -> rsp_err=1, latency READ_WAIT+2; correct model -> rsp_err=0.
REQ-039 Idle 20 cycles with req_valid=0 -> mem_enable=0, mem_r_w=1 throughout.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory request at a time from the execute stage,
// drives a simple single-port memory bank, and returns a response. Stores
// return the written data; loads return the sampled read data.
// Optional feature macro: LSU_WRITE_VERIFY_EN. When it is defined, each store
// is read back after the write. A mismatch between the read-back value and the
// written data sets rsp_err.
module load_store_unit #(
  parameter int READ_WAIT = 1  // read strobe cycles before sampling, 1..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  input  logic [7:0] mem_data_out,
  output logic [7:0] mem_data_in,
  output logic [3:0] mem_addr_in,
  output logic [3:0] mem_addr_out,
  output logic       mem_r_w,
  output logic       mem_enable
);

`ifdef LSU_WRITE_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, VERIFY, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP} state_t;
`endif

  // Final value of the wait counter; the read data is sampled on that edge.
  localparam logic [1:0] LAST_WAIT = 2'(READ_WAIT - 1);

  state_t     state_q;
  logic [1:0] wait_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic [7:0] mem_data_in_q;   // also serves as the latched store data
  logic [3:0] mem_addr_in_q;   // also serves as the latched store address
  logic [3:0] mem_addr_out_q;
  logic       mem_r_w_q;
  logic       mem_enable_q;
`ifdef LSU_WRITE_VERIFY_EN
  logic       rsp_err_q;
`endif

  // Request FSM with all outputs registered, so there are no combinational glitches toward memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wait_q         <= 2'd0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 8'h00;
      mem_data_in_q  <= 8'h00;
      mem_addr_in_q  <= 4'h0;
      mem_addr_out_q <= 4'h0;
      mem_r_w_q      <= 1'b1;
      mem_enable_q   <= 1'b0;
`ifdef LSU_WRITE_VERIFY_EN
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q  <= 1'b0;
            mem_enable_q <= 1'b1;
`ifdef LSU_WRITE_VERIFY_EN
            rsp_err_q    <= 1'b0;
`endif
            if (req_we) begin
              // The write strobe is low only for the single WRITE cycle.
              state_q       <= WRITE;
              mem_r_w_q     <= 1'b0;
              mem_addr_in_q <= req_addr;
              mem_data_in_q <= req_wdata;
            end else begin
              state_q        <= READ;
              mem_addr_out_q <= req_addr;
              wait_q         <= 2'd0;
            end
          end
        end
        WRITE: begin
          mem_r_w_q <= 1'b1;
`ifdef LSU_WRITE_VERIFY_EN
          // Read the just-written location back. The enable stays high.
          state_q        <= VERIFY;
          mem_addr_out_q <= mem_addr_in_q;
          wait_q         <= 2'd0;
`else
          state_q      <= RESP;
          mem_enable_q <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= mem_data_in_q;
`endif
        end
        READ: begin
          if (wait_q == LAST_WAIT) begin
            state_q      <= RESP;
            mem_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= mem_data_out;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
`ifdef LSU_WRITE_VERIFY_EN
        VERIFY: begin
          if (wait_q == LAST_WAIT) begin
            state_q      <= RESP;
            mem_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= mem_data_in_q;
            rsp_err_q    <= (mem_data_out != mem_data_in_q);
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          rsp_valid_q  <= 1'b0;
          mem_enable_q <= 1'b0;
          mem_r_w_q    <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_addr_in  = mem_addr_in_q;
  assign mem_addr_out = mem_addr_out_q;
  assign mem_r_w      = mem_r_w_q;
  assign mem_enable   = mem_enable_q;
`ifdef LSU_WRITE_VERIFY_EN
  assign rsp_err      = rsp_err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit. It includes a behavioural memory bank.
// LSU_WRITE_VERIFY_EN selects the store-verify expectations.
module tb_load_store_unit;
  localparam int RW = 2;
`ifdef LSU_WRITE_VERIFY_EN
  localparam int SLAT = RW + 2;  // store latency, cycles
  localparam int SRD  = RW;      // read-strobe cycles per store
`else
  localparam int SLAT = 2;
  localparam int SRD  = 0;
`endif

  logic       clk, reset;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_data_out, mem_data_in;
  logic [3:0] mem_addr_in, mem_addr_out;
  logic       mem_r_w, mem_enable;

  load_store_unit #(.READ_WAIT(RW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_addr_in(mem_addr_in), .mem_addr_out(mem_addr_out),
    .mem_r_w(mem_r_w), .mem_enable(mem_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory bank model: combinational read, write on the clock edge while strobed
  logic [7:0] mem [16];
  logic       force_zero;
  assign mem_data_out = force_zero ? 8'h00 : mem[mem_addr_out];

  // Preload known contents at reset, commit writes afterwards
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[5]  <= 8'h77;
      mem[15] <= 8'h3C;
    end else if (mem_enable && !mem_r_w) begin
      mem[mem_addr_in] <= mem_data_in;
    end
  end

  int cyc = 0;
  // Free-running cycle index used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int         first_cyc = 0;
  bit         in_rsp = 0;
  int         wr_pulses = 0;
  int         rd_cycles = 0;
  logic [3:0] last_wa = 4'h0;
  logic [7:0] last_wd = 8'h00;

  // Monitor: count memory strobes and score each response handshake
  always @(negedge clk) begin
    if (reset) begin
      in_rsp = 0;
    end else begin
      if (mem_enable && !mem_r_w) begin
        wr_pulses++;
        last_wa = mem_addr_in;
        last_wd = mem_data_in;
      end
      if (mem_enable && mem_r_w) rd_cycles++;
      if (rsp_valid && !in_rsp) begin
        in_rsp = 1;
        first_cyc = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        in_rsp = 0;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(first_cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Callers are positioned 1 time unit after a rising edge.
  task automatic issue(input bit we, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] er, input bit ee, input int lat, input bit push);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    if (push) sb.push_back('{er, ee, cyc, lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 100) begin @(posedge clk); #1; t++; end
    if (sb.size() != 0 || !req_ready) chk("rsp_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic txn(input bit we, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] er, input bit ee, input int lat);
    int w0, r0;
    w0 = wr_pulses;
    r0 = rd_cycles;
    issue(we, a, d, er, ee, lat, 1'b1);
    wait_idle();
    chk("write_strobe_cycles", 32'(wr_pulses - w0), we ? 32'd1 : 32'd0);
    chk("read_strobe_cycles", 32'(rd_cycles - r0), we ? 32'(SRD) : 32'(RW));
    if (we) begin
      chk("write_addr", 32'(last_wa), 32'(a));
      chk("write_data", 32'(last_wd), 32'(d));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'h00);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
    chk({tag, "_mem_r_w"}, 32'(mem_r_w), 32'd1);
    chk({tag, "_mem_addr_in"}, 32'(mem_addr_in), 32'h0);
    chk({tag, "_mem_addr_out"}, 32'(mem_addr_out), 32'h0);
    chk({tag, "_mem_data_in"}, 32'(mem_data_in), 32'h00);
  endtask

  initial begin
    int t, w0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;
    rsp_ready = 1'b1; force_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic store, then loads and a store/load round trip
    txn(1'b1, 4'h3, 8'hA5, 8'hA5, 1'b0, SLAT);
    txn(1'b0, 4'hF, 8'h00, 8'h3C, 1'b0, RW + 1);
    txn(1'b1, 4'h9, 8'hC3, 8'hC3, 1'b0, SLAT);
    txn(1'b0, 4'h9, 8'h00, 8'hC3, 1'b0, RW + 1);

    // Back-pressure in RESP while a new request is offered
    rsp_ready = 1'b0;
    w0 = wr_pulses;
    issue(1'b0, 4'hF, 8'h00, 8'h3C, 1'b0, RW + 1, 1'b1);
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("hold_rsp_seen", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h7; req_wdata = 8'hEE;
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", 32'(rsp_rdata), 32'h3C);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ignored_store_no_write", 32'(wr_pulses - w0), 32'd0);
    chk("ignored_store_mem", 32'(mem[7]), 32'h00);

    // Reset in the middle of a load
    issue(1'b0, 4'h5, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midread");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    txn(1'b0, 4'h5, 8'h00, 8'h77, 1'b0, RW + 1);

`ifdef LSU_WRITE_VERIFY_EN
    // Read-back mismatch, then a clean verify
    force_zero = 1'b1;
    txn(1'b1, 4'h2, 8'h5A, 8'h5A, 1'b1, SLAT);
    force_zero = 1'b0;
    txn(1'b1, 4'h2, 8'h5A, 8'h5A, 1'b0, SLAT);
`endif

    // Quiet bus while idle
    repeat (20) begin
      @(negedge clk);
      chk("idle_mem_enable", 32'(mem_enable), 32'd0);
      chk("idle_mem_r_w", 32'(mem_r_w), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
